// File: rtl/alu_rs_if.sv
// Dispatch, common-data-bus and issue signals of the ALU reservation station.
// The master drives dispatch and CDB broadcasts; the slave is the station itself.
interface alu_rs_if #(
  parameter int ROB_W = 4
);
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  logic              in_S;
  logic [OP_W-1:0]   in_Op;
  logic [DATA_W-1:0] in_A;
  logic [DATA_W-1:0] in_pc;
  logic [ROB_W-1:0]  in_Reorder;
  logic [DATA_W-1:0] in_Vj;
  logic [DATA_W-1:0] in_Vk;
  logic              in_Qj_S;
  logic              in_Qk_S;
  logic [ROB_W-1:0]  in_Qj;
  logic [ROB_W-1:0]  in_Qk;

  logic              CDB_ALU_S;
  logic [ROB_W-1:0]  CDB_ALU_Reorder;
  logic [DATA_W-1:0] CDB_ALU_Value;
  logic              CDB_LSB_S;
  logic [ROB_W-1:0]  CDB_LSB_Reorder;
  logic [DATA_W-1:0] CDB_LSB_Value;

  logic              RS_full;
  logic              ALU_S;
  logic [OP_W-1:0]   Op;
  logic [DATA_W-1:0] Vj;
  logic [DATA_W-1:0] Vk;
  logic [ROB_W-1:0]  Reorder;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] pc;

  modport master (
    output in_S, in_Op, in_A, in_pc, in_Reorder, in_Vj, in_Vk,
           in_Qj_S, in_Qk_S, in_Qj, in_Qk,
           CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
           CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value,
    input  RS_full, ALU_S, Op, Vj, Vk, Reorder, A, pc
  );

  modport slave (
    input  in_S, in_Op, in_A, in_pc, in_Reorder, in_Vj, in_Vk,
           in_Qj_S, in_Qk_S, in_Qj, in_Qk,
           CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
           CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value,
    output RS_full, ALU_S, Op, Vj, Vk, Reorder, A, pc
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops until both operands arrive
// on a CDB, then issues the lowest-index ready entry, one per cycle.
module alu_rs #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  input  logic    clear,
  alu_rs_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int IDX_W  = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_s;
  logic [RS_SIZE-1:0] r_qk_s;
  logic [OP_W-1:0]    r_op      [RS_SIZE];
  logic [DATA_W-1:0]  r_vj      [RS_SIZE];
  logic [DATA_W-1:0]  r_vk      [RS_SIZE];
  logic [DATA_W-1:0]  r_a       [RS_SIZE];
  logic [DATA_W-1:0]  r_pc      [RS_SIZE];
  logic [ROB_W-1:0]   r_qj      [RS_SIZE];
  logic [ROB_W-1:0]   r_qk      [RS_SIZE];
  logic [ROB_W-1:0]   r_reorder [RS_SIZE];

  logic               r_alu_s;
  logic [OP_W-1:0]    r_o_op;
  logic [DATA_W-1:0]  r_o_vj;
  logic [DATA_W-1:0]  r_o_vk;
  logic [ROB_W-1:0]   r_o_reorder;
  logic [DATA_W-1:0]  r_o_a;
  logic [DATA_W-1:0]  r_o_pc;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_disp_found;
  logic               w_iss_found;
  logic [IDX_W-1:0]   w_disp_idx;
  logic [IDX_W-1:0]   w_iss_idx;
  logic               w_upd_en;
  logic               w_disp_en;
  logic [DATA_W-1:0]  w_new_vj;
  logic [DATA_W-1:0]  w_new_vk;
  logic               w_new_qj_s;
  logic               w_new_qk_s;

  // Readiness uses the flags as registered, so a capture this cycle issues next cycle.
  assign w_ready   = r_busy & ~r_qj_s & ~r_qk_s;
  assign w_upd_en  = rdy_in && !clear && !rst_in;
  assign w_disp_en = w_upd_en && bus.in_S && w_disp_found;

  always_comb begin
    w_disp_found = 1'b0;
    w_disp_idx   = '0;
    w_iss_found  = 1'b0;
    w_iss_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_disp_found = 1'b1;
        w_disp_idx   = IDX_W'(i);
      end
      if (w_ready[i]) begin
        w_iss_found = 1'b1;
        w_iss_idx   = IDX_W'(i);
      end
    end
  end

  // Same-cycle CDB forwarding for the operands of the instruction being dispatched.
  always_comb begin
    w_new_vj   = bus.in_Vj;
    w_new_qj_s = bus.in_Qj_S;
    w_new_vk   = bus.in_Vk;
    w_new_qk_s = bus.in_Qk_S;
    if (bus.in_Qj_S) begin
      if (bus.CDB_ALU_S && (bus.CDB_ALU_Reorder == bus.in_Qj)) begin
        w_new_vj   = bus.CDB_ALU_Value;
        w_new_qj_s = 1'b0;
      end else if (bus.CDB_LSB_S && (bus.CDB_LSB_Reorder == bus.in_Qj)) begin
        w_new_vj   = bus.CDB_LSB_Value;
        w_new_qj_s = 1'b0;
      end
    end
    if (bus.in_Qk_S) begin
      if (bus.CDB_ALU_S && (bus.CDB_ALU_Reorder == bus.in_Qk)) begin
        w_new_vk   = bus.CDB_ALU_Value;
        w_new_qk_s = 1'b0;
      end else if (bus.CDB_LSB_S && (bus.CDB_LSB_Reorder == bus.in_Qk)) begin
        w_new_vk   = bus.CDB_LSB_Value;
        w_new_qk_s = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy      <= '0;
      r_alu_s     <= 1'b0;
      r_o_op      <= '0;
      r_o_vj      <= '0;
      r_o_vk      <= '0;
      r_o_reorder <= '0;
      r_o_a       <= '0;
      r_o_pc      <= '0;
    end else if (clear) begin
      r_busy  <= '0;
      r_alu_s <= 1'b0;
    end else if (!rdy_in) begin
      r_alu_s <= 1'b0;
    end else begin
      r_alu_s <= w_iss_found;
      if (w_iss_found) begin
        r_busy[w_iss_idx] <= 1'b0;
        r_o_op            <= r_op[w_iss_idx];
        r_o_vj            <= r_vj[w_iss_idx];
        r_o_vk            <= r_vk[w_iss_idx];
        r_o_reorder       <= r_reorder[w_iss_idx];
        r_o_a             <= r_a[w_iss_idx];
        r_o_pc            <= r_pc[w_iss_idx];
      end
      // The dispatch slot comes from registered busy bits, so it never aliases the issuing entry.
      if (w_disp_en) begin
        r_busy[w_disp_idx] <= 1'b1;
      end
    end
  end

  // Entry payload needs no reset: it is only observed while the busy bit is set.
  always_ff @(posedge clk_in) begin
    if (w_upd_en) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_s[i]) begin
          if (bus.CDB_ALU_S && (bus.CDB_ALU_Reorder == r_qj[i])) begin
            r_vj[i]   <= bus.CDB_ALU_Value;
            r_qj_s[i] <= 1'b0;
          end else if (bus.CDB_LSB_S && (bus.CDB_LSB_Reorder == r_qj[i])) begin
            r_vj[i]   <= bus.CDB_LSB_Value;
            r_qj_s[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_s[i]) begin
          if (bus.CDB_ALU_S && (bus.CDB_ALU_Reorder == r_qk[i])) begin
            r_vk[i]   <= bus.CDB_ALU_Value;
            r_qk_s[i] <= 1'b0;
          end else if (bus.CDB_LSB_S && (bus.CDB_LSB_Reorder == r_qk[i])) begin
            r_vk[i]   <= bus.CDB_LSB_Value;
            r_qk_s[i] <= 1'b0;
          end
        end
      end
      if (w_disp_en) begin
        r_op[w_disp_idx]      <= bus.in_Op;
        r_vj[w_disp_idx]      <= w_new_vj;
        r_vk[w_disp_idx]      <= w_new_vk;
        r_qj_s[w_disp_idx]    <= w_new_qj_s;
        r_qk_s[w_disp_idx]    <= w_new_qk_s;
        r_qj[w_disp_idx]      <= bus.in_Qj;
        r_qk[w_disp_idx]      <= bus.in_Qk;
        r_reorder[w_disp_idx] <= bus.in_Reorder;
        r_a[w_disp_idx]       <= bus.in_A;
        r_pc[w_disp_idx]      <= bus.in_pc;
      end
    end
  end

  assign bus.RS_full = &r_busy;
  assign bus.ALU_S   = r_alu_s;
  assign bus.Op      = r_o_op;
  assign bus.Vj      = r_o_vj;
  assign bus.Vk      = r_o_vk;
  assign bus.Reorder = r_o_reorder;
  assign bus.A       = r_o_a;
  assign bus.pc      = r_o_pc;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: each scenario task drives dispatch/CDB traffic, queues the
// expected issue records and compares them when ALU_S fires.
module tb_alu_rs;
  localparam int ROB_W = 4;
  localparam logic [5:0] OP_ADD = 6'd1;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  rob;
    logic [31:0] a;
    logic [31:0] pc;
  } iss_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  iss_t exp_q[$];
  iss_t e;

  alu_rs_if #(.ROB_W(ROB_W)) bus ();

  alu_rs #(.RS_SIZE(16), .ROB_W(ROB_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .clear  (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic iss_t mk(input logic [5:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [3:0] rob);
    iss_t r;
    r.op  = op;
    r.vj  = vj;
    r.vk  = vk;
    r.rob = rob;
    r.a   = 32'hA000_0000 | 32'(rob);
    r.pc  = 32'h0000_4000 + 32'(rob) * 32'd4;
    return r;
  endfunction

  function automatic iss_t got();
    iss_t r;
    r.op  = bus.Op;
    r.vj  = bus.Vj;
    r.vk  = bus.Vk;
    r.rob = bus.Reorder;
    r.a   = bus.A;
    r.pc  = bus.pc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_S      = 1'b0;
    bus.CDB_ALU_S = 1'b0;
    bus.CDB_LSB_S = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic qj_s, input logic [3:0] qj,
                      input logic qk_s, input logic [3:0] qk, input logic [3:0] rob);
    iss_t t;
    t = mk(op, vj, vk, rob);
    bus.in_S       = 1'b1;
    bus.in_Op      = op;
    bus.in_Vj      = vj;
    bus.in_Vk      = vk;
    bus.in_Qj_S    = qj_s;
    bus.in_Qj      = qj;
    bus.in_Qk_S    = qk_s;
    bus.in_Qk      = qk;
    bus.in_Reorder = rob;
    bus.in_A       = t.a;
    bus.in_pc      = t.pc;
  endtask

  task automatic cdb_alu(input logic [3:0] tag, input logic [31:0] val);
    bus.CDB_ALU_S       = 1'b1;
    bus.CDB_ALU_Reorder = tag;
    bus.CDB_ALU_Value   = val;
  endtask

  task automatic cdb_lsb(input logic [3:0] tag, input logic [31:0] val);
    bus.CDB_LSB_S       = 1'b1;
    bus.CDB_LSB_Reorder = tag;
    bus.CDB_LSB_Value   = val;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; clr = 1'b1;
    idle();
    tick();
    rdy = 1'b1; clr = 1'b0;
    disp(OP_ADD, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (bus.ALU_S !== 1'b0 || bus.RS_full !== 1'b0 || got() !== '0) begin
      errors++;
      $display("FAIL reset_state: ALU_S=%b RS_full=%b out=%h required 0/0/0", bus.ALU_S, bus.RS_full, got());
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL reset_dispatch_ignored: ALU_S=%b required 0", bus.ALU_S);
    end
  endtask

  task automatic test_basic();
    exp_q.delete();
    disp(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    exp_q.push_back(mk(OP_ADD, 32'd5, 32'd7, 4'd3));
    tick(); idle();
    checks++;
    if (bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: ALU_S=%b required 0 in cycle 1", bus.ALU_S);
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL basic_issue: ALU_S=%b required 1", bus.ALU_S);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL basic_issue: got %h required %h", got(), e);
      end
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b0 || bus.Vj !== 32'd5 || bus.Reorder !== 4'd3) begin
      errors++;
      $display("FAIL basic_hold: ALU_S=%b Vj=%h Reorder=%0d required 0/5/3", bus.ALU_S, bus.Vj, bus.Reorder);
    end
  endtask

  task automatic test_cdb_capture();
    exp_q.delete();
    disp(6'd4, 32'hDEAD_BEEF, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0, 4'd7);
    exp_q.push_back(mk(6'd4, 32'h10, 32'd9, 4'd7));
    tick(); idle();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.ALU_S !== 1'b0) begin
        errors++;
        $display("FAIL cdb_wait: ALU_S=%b required 0 in cycle %0d", bus.ALU_S, c);
      end
      if (c == 1) cdb_alu(4'd5, 32'h55);
      if (c == 3) begin
        cdb_alu(4'd2, 32'h10);
        cdb_lsb(4'd2, 32'h99);
      end
      tick(); idle();
    end
    checks++;
    if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL cdb_issue: ALU_S=%b required 1 in cycle 5", bus.ALU_S);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL cdb_issue: got %h required %h", got(), e);
      end
    end
    tick();
  endtask

  task automatic test_dispatch_forward();
    exp_q.delete();
    disp(6'd5, 32'h123, 32'h0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd8);
    cdb_lsb(4'd6, 32'hAB);
    exp_q.push_back(mk(6'd5, 32'h123, 32'hAB, 4'd8));
    tick(); idle();
    tick();
    checks++;
    if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL fwd_issue: ALU_S=%b required 1", bus.ALU_S);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL fwd_issue: got %h required %h", got(), e);
      end
    end
    tick();
  endtask

  task automatic test_full();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      disp(OP_ADD, 32'hDEAD_0000 | 32'(i), 32'h1000 + 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    checks++;
    if (bus.RS_full !== 1'b1 || bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL full_set: RS_full=%b ALU_S=%b required 1/0", bus.RS_full, bus.ALU_S);
    end
    disp(OP_ADD, 32'h1313, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
    tick(); idle();
    cdb_alu(4'd9, 32'h900);
    exp_q.push_back(mk(OP_ADD, 32'h900, 32'h1009, 4'd9));
    tick(); idle();
    checks++;
    if (bus.RS_full !== 1'b1 || bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL full_capture: RS_full=%b ALU_S=%b required 1/0", bus.RS_full, bus.ALU_S);
    end
    disp(OP_ADD, 32'h77, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    tick(); idle();
    checks++;
    if (bus.ALU_S !== 1'b1 || bus.RS_full !== 1'b0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL full_issue: ALU_S=%b RS_full=%b required 1/0", bus.ALU_S, bus.RS_full);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL full_issue: got %h required %h", got(), e);
      end
    end
    disp(6'd9, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    exp_q.push_back(mk(6'd9, 32'h55, 32'h66, 4'd12));
    tick(); idle();
    checks++;
    if (bus.ALU_S !== 1'b0 || bus.RS_full !== 1'b1) begin
      errors++;
      $display("FAIL full_refill: ALU_S=%b RS_full=%b required 0/1", bus.ALU_S, bus.RS_full);
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL full_reissue: ALU_S=%b required 1", bus.ALU_S);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL full_reissue: got %h required %h", got(), e);
      end
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL full_dropped: ALU_S=%b required 0", bus.ALU_S);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.RS_full !== 1'b0 || bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL full_flush: RS_full=%b ALU_S=%b required 0/0", bus.RS_full, bus.ALU_S);
    end
  endtask

  task automatic test_priority();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      disp(6'd2, 32'h20 + 32'(i), 32'h40 + 32'(i), (i % 2) == 1, 4'(i), (i % 2) == 0, 4'(i), 4'(i));
      tick();
    end
    idle();
    cdb_alu(4'd1, 32'h111);
    cdb_lsb(4'd4, 32'h444);
    exp_q.push_back(mk(6'd2, 32'h111, 32'h41, 4'd1));
    exp_q.push_back(mk(6'd2, 32'h24, 32'h444, 4'd4));
    tick(); idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL prio_issue%0d: ALU_S=%b required 1", k, bus.ALU_S);
      end else begin
        e = exp_q.pop_front();
        if (got() !== e) begin
          errors++;
          $display("FAIL prio_issue%0d: got %h required %h", k, got(), e);
        end
      end
      tick();
    end
    checks++;
    if (bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL prio_after: ALU_S=%b required 0", bus.ALU_S);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_clear();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      disp(6'd3, 32'h0, 32'h0, 1'b1, 4'(i + 8), 1'b0, 4'd0, 4'(i));
      tick();
    end
    disp(6'd3, 32'h4, 32'h4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    tick();
    idle();
    clr = 1'b1;
    disp(6'd3, 32'h5, 32'h5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    cdb_alu(4'd8, 32'hAA);
    tick();
    clr = 1'b0;
    idle();
    checks++;
    if (bus.ALU_S !== 1'b0 || bus.RS_full !== 1'b0) begin
      errors++;
      $display("FAIL clear_now: ALU_S=%b RS_full=%b required 0/0", bus.ALU_S, bus.RS_full);
    end
    cdb_alu(4'd9, 32'h99);
    cdb_lsb(4'd10, 32'hA0);
    for (int c = 0; c < 3; c++) begin
      tick(); idle();
      checks++;
      if (bus.ALU_S !== 1'b0) begin
        errors++;
        $display("FAIL clear_stale%0d: ALU_S=%b required 0", c, bus.ALU_S);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vj, vk;
    logic [5:0]  op;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        checks++;
        if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_issue%0d: ALU_S=%b required 1", k, bus.ALU_S);
        end else begin
          e = exp_q.pop_front();
          if (got() !== e) begin
            errors++;
            $display("FAIL b2b_issue%0d: got %h required %h", k, got(), e);
          end
        end
      end
      if (k < 6) begin
        vj = $urandom;
        vk = $urandom;
        op = 6'($urandom_range(0, 63));
        disp(op, vj, vk, 1'b0, 4'd0, 1'b0, 4'd0, 4'(k));
        exp_q.push_back(mk(op, vj, vk, 4'(k)));
      end else begin
        idle();
      end
      tick();
    end
    idle();
    checks++;
    if (bus.ALU_S !== 1'b0 || bus.RS_full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: ALU_S=%b RS_full=%b required 0/0", bus.ALU_S, bus.RS_full);
    end
  endtask

  task automatic test_rdy_stall();
    exp_q.delete();
    disp(6'd7, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    exp_q.push_back(mk(6'd7, 32'hA, 32'hB, 4'd10));
    tick();
    rdy = 1'b0;
    disp(6'd7, 32'hC, 32'hD, 1'b0, 4'd0, 1'b0, 4'd0, 4'd11);
    tick();
    rdy = 1'b1;
    idle();
    checks++;
    if (bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: ALU_S=%b required 0", bus.ALU_S);
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL stall_issue: ALU_S=%b required 1", bus.ALU_S);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL stall_issue: got %h required %h", got(), e);
      end
    end
    tick();
    checks++;
    if (bus.ALU_S !== 1'b0) begin
      errors++;
      $display("FAIL stall_dropped: ALU_S=%b required 0", bus.ALU_S);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    disp(OP_ADD, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    exp_q.push_back(mk(OP_ADD, 32'h11, 32'h22, 4'd1));
    tick();
    disp(6'd3, 32'h0, 32'h33, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
    tick();
    checks++;
    if (bus.ALU_S !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL rmid_issue: ALU_S=%b required 1", bus.ALU_S);
    end else begin
      e = exp_q.pop_front();
      if (got() !== e) begin
        errors++;
        $display("FAIL rmid_issue: got %h required %h", got(), e);
      end
    end
    disp(6'd3, 32'h55, 32'h56, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    tick();
    idle();
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    checks++;
    if (bus.ALU_S !== 1'b0 || bus.RS_full !== 1'b0 || got() !== '0) begin
      errors++;
      $display("FAIL rmid_state: ALU_S=%b RS_full=%b out=%h required 0/0/0", bus.ALU_S, bus.RS_full, got());
    end
    cdb_alu(4'd3, 32'h3333);
    for (int c = 0; c < 3; c++) begin
      tick(); idle();
      checks++;
      if (bus.ALU_S !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale%0d: ALU_S=%b required 0", c, bus.ALU_S);
      end
    end
  endtask

  initial begin
    idle();
    bus.in_Op = '0; bus.in_Vj = '0; bus.in_Vk = '0; bus.in_A = '0; bus.in_pc = '0;
    bus.in_Qj_S = 1'b0; bus.in_Qk_S = 1'b0; bus.in_Qj = '0; bus.in_Qk = '0; bus.in_Reorder = '0;
    bus.CDB_ALU_Reorder = '0; bus.CDB_ALU_Value = '0;
    bus.CDB_LSB_Reorder = '0; bus.CDB_LSB_Value = '0;
    test_reset();
    test_basic();
    test_cdb_capture();
    test_dispatch_forward();
    test_full();
    test_priority();
    test_clear();
    test_back_to_back();
    test_rdy_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 16, SHALL set the number of reservation-station entries (power of two, 2..32).
REQ-002 Parameter ROB_W, default 4, SHALL set the ROB tag width; DATA_W is fixed at 32 and OP_W at 6.
REQ-003 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 clear  input  1  flush due to ROB misprediction.
REQ-007 in_S  input  1  dispatch valid; in_Op OP_W, in_A 32, in_pc 32, in_Reorder ROB_W carry the instruction fields.
REQ-008 in_Vj/in_Vk  input  32  operand values; in_Qj_S/in_Qk_S 1 pending flags; in_Qj/in_Qk ROB_W producer tags.
REQ-009 CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value and CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value  input  1/ROB_W/32  result broadcasts.
REQ-010 RS_full  output  1  no free entry.
REQ-011 ALU_S  output  1  issue valid; Op OP_W, Vj 32, Vk 32, Reorder ROB_W, A 32, pc 32 are registered issue fields.

Function
REQ-012 Each entry SHALL hold busy, Op, Vj, Vk, Qj_S, Qj, Qk_S, Qk, Reorder, A, pc.
REQ-013 Dispatch SHALL write in_* into the lowest-index non-busy entry when in_S=1 and rdy_in=1, setting busy.
REQ-014 A dispatched operand whose pending tag equals a same-cycle valid CDB tag SHALL be stored with that CDB value and its Q_S cleared.
REQ-015 Every cycle, each busy entry with Qj_S=1 (or Qk_S=1) whose tag matches a valid CDB broadcast SHALL capture that value and clear the flag; the ALU bus SHALL win if both CDBs match the same tag.
REQ-016 An entry SHALL be ready when busy=1, Qj_S=0 and Qk_S=0, using flags registered at the start of the cycle.
REQ-017 Issue SHALL select the lowest-index ready entry, register its fields onto the outputs with ALU_S=1 next cycle, and clear its busy bit.
REQ-018 With no ready entry, ALU_S SHALL be 0 next cycle and the data outputs SHALL hold their previous values.
REQ-019 Issue-to-ALU latency SHALL be one cycle; dispatch-to-earliest-issue SHALL be one cycle (dispatch in cycle N, ALU_S=1 in cycle N+2 at the earliest).
REQ-020 At most one dispatch and one issue per cycle; both SHALL be allowed in the same cycle on different entries.
REQ-021 RS_full SHALL be combinational and equal to the AND of all busy bits; dispatch with in_S=1 while RS_full=1 is illegal and SHALL be ignored.
REQ-022 An issued entry freed in cycle N SHALL be dispatchable in cycle N+1, not in cycle N.
REQ-023 clear=1 SHALL clear all busy bits and ALU_S next cycle; it SHALL override simultaneous dispatch, CDB capture and issue.
REQ-024 rdy_in=0 with rst_in=0 and clear=0 SHALL hold all entries, and ALU_S SHALL be 0 next cycle.
REQ-025 in_Op/Op encodings SHALL be the shared opcode definitions; the block SHALL not interpret Op.

Reset
REQ-026 rst_in=1 at a clock edge SHALL clear all busy bits, ALU_S and the Op, Vj, Vk, Reorder, A and pc outputs to 0, regardless of rdy_in or clear.
REQ-027 After reset RS_full SHALL be 0, and reset asserted mid-operation SHALL discard all pending entries.

Verification
REQ-028 Dispatch ADD, Qj_S=Qk_S=0, Vj=5, Vk=7, Reorder=3 in cycle 0 -> ALU_S=1, Vj=5, Vk=7, Reorder=3 in cycle 2.
REQ-029 Dispatch with Qj_S=1, Qj=2; CDB_ALU_S=1, Reorder=2, Value=0x10 in cycle 3 -> issue in cycle 5 with Vj=0x10.
REQ-030 Dispatch with Qk=6 in the same cycle as CDB_LSB broadcasting tag 6, value 0xAB -> entry ready immediately, Vk=0xAB at issue.
REQ-031 Fill all 16 entries with pending operands -> RS_full=1; broadcast one tag -> that entry issues, and RS_full=0 the cycle after issue.
REQ-032 Entries 1 and 4 both ready -> entry 1 issues first, then entry 4 the next cycle.
REQ-033 clear=1 with 5 busy entries and a simultaneous dispatch -> next cycle all entries free, ALU_S=0, RS_full=0.
